debug_loader: RTL and testbench
===============================

DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning instruction word width.
REQ-002 The block SHALL have parameter MAX_INSTR, default 256, meaning instruction-memory capacity in words.
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, meaning pipeline reset pulse length in cycles.
REQ-004 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning end-of-program marker word.
REQ-005 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_rst  in  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_rx_data  in  8  byte from the serial receiver.
REQ-008 The block SHALL have port i_rx_valid  in  1  i_rx_data is valid this cycle.
REQ-009 The block SHALL have port o_rx_ready  out  1  the block accepts a byte this cycle.
REQ-010 The block SHALL have ports i_start, i_stop, i_step_mode and i_step  in  1 each  load command, run abort, single-step enable and one-cycle step request.
REQ-011 The block SHALL have ports o_we_IF  out  1  and  o_instruction_data  out  NB_DATA  driving the pipeline instruction-memory write port.
REQ-012 The block SHALL have ports o_pipe_rst_n  out  1  and  o_halt  out  1  driving the pipeline reset and halt inputs.
REQ-013 The block SHALL have ports o_instr_count  out  $clog2(MAX_INSTR)+1  words written; o_overflow  out  1  sticky capacity error; o_state  out  3  current state.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, FLUSH, RUN and DONE.
REQ-015 In IDLE the block SHALL drive o_pipe_rst_n=0, o_halt=1, o_rx_ready=0 and o_we_IF=0.
REQ-016 In IDLE or DONE, i_start=1 SHALL move the FSM to LOAD and clear the byte counter, o_instr_count and o_overflow.
REQ-017 In LOAD the block SHALL drive o_rx_ready=1, o_pipe_rst_n=1 and o_halt=0.
REQ-018 Each i_rx_valid&&o_rx_ready handshake SHALL shift the byte into the assembly register MSB-first; 4 bytes make one word.
REQ-019 On the cycle after the 4th-byte handshake, o_we_IF SHALL be 1 for exactly one cycle, o_instruction_data SHALL hold the assembled word, and o_instr_count SHALL increment.
REQ-020 The output word register SHALL be separate from the assembly register, so a byte accepted during the write cycle is kept and counted toward the next word.
REQ-021 A word equal to HALT_WORD SHALL still be written, and the FSM SHALL then enter FLUSH.
REQ-022 When o_instr_count reaches MAX_INSTR, o_overflow SHALL set, o_rx_ready SHALL drop, and the FSM SHALL enter FLUSH.
REQ-023 In FLUSH the block SHALL drive o_pipe_rst_n=0, o_halt=1 and o_rx_ready=0 for exactly RST_CYCLES cycles, then enter RUN.
REQ-024 In RUN with i_step_mode=0 the block SHALL drive o_pipe_rst_n=1 and o_halt=0.
REQ-025 In RUN with i_step_mode=1, o_halt SHALL be 1 except for one cycle following each i_step pulse.
REQ-026 An i_step held high SHALL count as one step; edge detection is required.
REQ-027 In RUN, i_stop=1 SHALL move the FSM to DONE, where o_halt=1, o_pipe_rst_n=1 and o_rx_ready=0.
REQ-028 i_stop outside RUN and i_start outside IDLE/DONE SHALL be ignored; when both are asserted in IDLE/DONE, i_start SHALL win.
REQ-029 Bytes presented while o_rx_ready=0 SHALL be neither consumed nor stored.

Reset
REQ-030 Asserting i_rst SHALL immediately force IDLE with o_we_IF=0, o_instruction_data=0, o_instr_count=0, o_overflow=0, o_pipe_rst_n=0, o_halt=1 and o_rx_ready=0.
REQ-031 A reset mid-LOAD SHALL discard any partial word; a subsequent load SHALL restart at byte 0.

Structure
REQ-032 The state encoding and HALT_WORD SHALL live in shared package mips_debug_pkg.
REQ-033 A single sub-module, word_assembler (byte counter plus shift register plus word-done strobe), SHALL be used.

Verification
REQ-034 Start, then bytes 20 01 00 0F -> exactly one o_we_IF pulse with 0x2001000F, and o_instr_count=1.
REQ-035 Start, 3 words plus FF FF FF FF -> 4 writes, then o_pipe_rst_n low for exactly 2 cycles, then RUN with o_halt=0.
REQ-036 MAX_INSTR=4 with 5 words sent -> 4 writes, o_overflow=1, and the 5th word not written.
REQ-037 RUN with i_step_mode=1 and i_step held high 3 cycles -> exactly one o_halt=0 cycle.
REQ-038 i_rst asserted after 2 bytes, then a fresh start with 4 bytes A0 01 00 00 -> a single write of 0xA0010000.
REQ-039 Back-to-back valid bytes (no gaps) for 2 words -> 2 writes 4 cycles apart, with no byte lost.

Source files
------------

// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug loader: FSM state encoding and the
// default end-of-program marker word.
package mips_debug_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam int unsigned BYTE_W            = 8;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted serial bytes MSB-first into NB_DATA-bit words; word_done
// flags the byte that completes a word, with word_next holding that word.
module word_assembler
  import mips_debug_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [NB_DATA-1:0] word_next,
  output logic               word_done
);

  localparam int unsigned NB_BYTES = NB_DATA / BYTE_W;
  localparam int unsigned CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  // Only the low bytes need storing; the completing byte arrives live.
  logic [NB_DATA-BYTE_W-1:0] shift_q;
  logic [CNT_W-1:0]          cnt_q;

  assign word_next = {shift_q, byte_in};
  assign word_done = byte_valid && (cnt_q == CNT_W'(NB_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= word_next[NB_DATA-BYTE_W-1:0];
      cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/debug_loader.sv
// Debug loader: receives a program byte-stream into the pipeline instruction
// memory, pulses the pipeline reset, then runs it freely or single-stepped.
module debug_loader
  import mips_debug_pkg::*;
#(
  parameter int unsigned        NB_DATA    = 32,
  parameter int unsigned        MAX_INSTR  = 256,
  parameter int unsigned        RST_CYCLES = 2,
  parameter logic [NB_DATA-1:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic                       o_rx_ready,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_step_mode,
  input  logic                       i_step,
  output logic                       o_we_IF,
  output logic [NB_DATA-1:0]         o_instruction_data,
  output logic                       o_pipe_rst_n,
  output logic                       o_halt,
  output logic [$clog2(MAX_INSTR):0] o_instr_count,
  output logic                       o_overflow,
  output logic [2:0]                 o_state
);

  localparam int unsigned CW = $clog2(MAX_INSTR) + 1;
  localparam int unsigned FW = $clog2(RST_CYCLES + 1);

  state_t               state, next_state;
  logic [FW-1:0]        flush_cnt;
  logic                 step_d, step_go;
  logic                 load_start, byte_fire, word_done;
  logic [NB_DATA-1:0]   word_next;

  assign byte_fire = i_rx_valid && o_rx_ready;
  assign o_state   = state;

  word_assembler #(.NB_DATA(NB_DATA)) u_asm (
    .clk        (clk),
    .rst        (i_rst),
    .clr        (load_start),
    .byte_valid (byte_fire),
    .byte_in    (i_rx_data),
    .word_next  (word_next),
    .word_done  (word_done)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_we_IF            <= 1'b0;
      o_instruction_data <= '0;
      o_instr_count      <= '0;
      o_overflow         <= 1'b0;
      flush_cnt          <= '0;
      step_d             <= 1'b0;
      step_go            <= 1'b0;
    end else begin
      o_we_IF   <= word_done;
      step_d    <= i_step;
      step_go   <= (state == RUN) && i_step && !step_d;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (load_start) begin
        o_instr_count <= '0;
        o_overflow    <= 1'b0;
      end else if (word_done) begin
        o_instruction_data <= word_next;
        o_instr_count      <= o_instr_count + 1'b1;
        if (o_instr_count == CW'(MAX_INSTR - 1)) o_overflow <= 1'b1;
      end
    end
  end

  // The FLUSH decision is taken on the completing byte, so the final write
  // lands in the first FLUSH cycle and no further byte is accepted.
  always_comb begin
    next_state   = state;
    o_rx_ready   = 1'b0;
    o_pipe_rst_n = 1'b0;
    o_halt       = 1'b1;
    load_start   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        o_rx_ready   = 1'b1;
        o_pipe_rst_n = 1'b1;
        o_halt       = 1'b0;
        if (word_done && (word_next == HALT_WORD ||
                          o_instr_count == CW'(MAX_INSTR - 1)))
          next_state = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FW'(RST_CYCLES - 1)) next_state = RUN;
      end
      RUN: begin
        o_pipe_rst_n = 1'b1;
        o_halt       = i_step_mode && !step_go;
        if (i_stop) next_state = DONE;
      end
      DONE: begin
        o_pipe_rst_n = 1'b1;
        if (i_start) begin
          next_state = LOAD;
          load_start = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_loader.sv
// Directed self-checking bench for debug_loader: default instance for load,
// flush, run, step and reset; a MAX_INSTR=4 instance for capacity overflow.
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic        step_mode = 1'b0, step = 1'b0;
  logic        rx_ready, we, pipe_rst_n, halt, ovf;
  logic [31:0] idata;
  logic [8:0]  icount;
  logic [2:0]  state;

  logic [7:0]  s_rx_data = '0;
  logic        s_rx_valid = 1'b0, s_start = 1'b0;
  logic        s_rx_ready, s_we, s_pipe_rst_n, s_halt, s_ovf;
  logic [31:0] s_idata;
  logic [2:0]  s_icount;
  logic [2:0]  s_state;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, wr_cnt = 0, rstlo_cnt = 0, hl_cnt = 0, s_wr_cnt = 0;
  logic [31:0] wr_word [64];
  int          wr_cyc  [64];
  logic [31:0] s_last = '0;
  int base_wr, base_rstlo, base_hl;

  always #5 clk = ~clk;

  debug_loader dut (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .i_start(start), .i_stop(stop),
    .i_step_mode(step_mode), .i_step(step), .o_we_IF(we),
    .o_instruction_data(idata), .o_pipe_rst_n(pipe_rst_n), .o_halt(halt),
    .o_instr_count(icount), .o_overflow(ovf), .o_state(state)
  );

  debug_loader #(.MAX_INSTR(4)) dut_s (
    .clk(clk), .i_rst(rst), .i_rx_data(s_rx_data), .i_rx_valid(s_rx_valid),
    .o_rx_ready(s_rx_ready), .i_start(s_start), .i_stop(1'b0),
    .i_step_mode(1'b0), .i_step(1'b0), .o_we_IF(s_we),
    .o_instruction_data(s_idata), .o_pipe_rst_n(s_pipe_rst_n), .o_halt(s_halt),
    .o_instr_count(s_icount), .o_overflow(s_ovf), .o_state(s_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wr_word[wr_cnt % 64] <= idata;
      wr_cyc[wr_cnt % 64]  <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (!pipe_rst_n) rstlo_cnt <= rstlo_cnt + 1;
    if (state == 3'd3 && !halt) hl_cnt <= hl_cnt + 1;
    if (s_we) begin
      s_wr_cnt <= s_wr_cnt + 1;
      s_last   <= s_idata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the byte valid until it is taken; leaves valid high for streaming.
  task automatic push(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
    tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) push(w[31 - 8*i -: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    check("rst_state", state, 3'd0);
    check("rst_we", we, 1'b0);
    check("rst_data", idata, 32'h0);
    check("rst_count", icount, 9'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_pipe_rst_n", pipe_rst_n, 1'b0);
    check("rst_halt", halt, 1'b1);
    check("rst_ready", rx_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_ready", rx_ready, 1'b0);

    // Single word load
    pulse_start();
    check("load_state", state, 3'd1);
    check("load_ready", rx_ready, 1'b1);
    check("load_pipe_rst_n", pipe_rst_n, 1'b1);
    check("load_halt", halt, 1'b0);
    base_wr = wr_cnt;
    push_word(32'h2001_000F);
    rx_valid = 1'b0;
    repeat (2) tick();
    check("w1_writes", wr_cnt - base_wr, 1);
    check("w1_word", wr_word[base_wr % 64], 32'h2001_000F);
    check("w1_count", icount, 9'd1);
    check("w1_still_load", state, 3'd1);

    // start and stop are ignored while loading
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_in_load_ignored", icount, 9'd1);
    check("stop_in_load_ignored", state, 3'd1);

    // Reset mid-word discards the partial word
    push(8'h11);
    push(8'h22);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_state", state, 3'd0);
    check("arst_count", icount, 9'd0);
    check("arst_data", idata, 32'h0);
    check("arst_halt", halt, 1'b1);
    check("arst_ready", rx_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    base_wr = wr_cnt;
    push_word(32'hA001_0000);
    rx_valid = 1'b0;
    repeat (2) tick();
    check("rl_writes", wr_cnt - base_wr, 1);
    check("rl_word", wr_word[base_wr % 64], 32'hA001_0000);
    check("rl_count", icount, 9'd1);

    // Program with halt word, flush, run
    do_reset();
    pulse_start();
    base_wr    = wr_cnt;
    base_rstlo = rstlo_cnt;
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    push_word(32'h0000_0013);
    push_word(32'hFFFF_FFFF);
    rx_valid = 1'b0;
    check("halt_to_flush", state, 3'd2);
    check("flush_ready", rx_ready, 1'b0);
    repeat (4) tick();
    check("prog_writes", wr_cnt - base_wr, 4);
    check("prog_w0", wr_word[base_wr % 64], 32'h1234_5678);
    check("prog_w3", wr_word[(base_wr + 3) % 64], 32'hFFFF_FFFF);
    check("prog_count", icount, 9'd4);
    check("flush_len", rstlo_cnt - base_rstlo, 2);
    check("run_state", state, 3'd3);
    check("run_halt", halt, 1'b0);
    check("run_pipe_rst_n", pipe_rst_n, 1'b1);
    check("prog_ovf", ovf, 1'b0);

    // Single-step: held step counts once
    step_mode = 1'b1;
    tick();
    check("step_idle_halt", halt, 1'b1);
    base_hl = hl_cnt;
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    repeat (3) tick();
    check("step_held_once", hl_cnt - base_hl, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (2) tick();
    check("step_second", hl_cnt - base_hl, 2);

    // Stop, then start+stop in DONE: start wins
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("done_state", state, 3'd4);
    check("done_halt", halt, 1'b1);
    check("done_pipe_rst_n", pipe_rst_n, 1'b1);
    check("done_ready", rx_ready, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("restart_state", state, 3'd1);
    check("restart_count", icount, 9'd0);

    // Back-to-back bytes, two words
    base_wr = wr_cnt;
    for (int unsigned i = 1; i <= 8; i++) push(8'(i));
    rx_valid = 1'b0;
    repeat (3) tick();
    check("b2b_writes", wr_cnt - base_wr, 2);
    check("b2b_w0", wr_word[base_wr % 64], 32'h0102_0304);
    check("b2b_w1", wr_word[(base_wr + 1) % 64], 32'h0506_0708);
    check("b2b_spacing", wr_cyc[(base_wr + 1) % 64] - wr_cyc[base_wr % 64], 4);
    check("b2b_count", icount, 9'd2);

    // Capacity overflow on the MAX_INSTR=4 instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("s_load_state", s_state, 3'd1);
    for (int unsigned i = 1; i <= 20; i++) begin
      s_rx_data  = 8'(i);
      s_rx_valid = 1'b1;
      tick();
    end
    s_rx_valid = 1'b0;
    repeat (4) tick();
    check("ovf_writes", s_wr_cnt, 4);
    check("ovf_last_word", s_last, 32'h0D0E_0F10);
    check("ovf_count", s_icount, 3'd4);
    check("ovf_flag", s_ovf, 1'b1);
    check("ovf_ready", s_rx_ready, 1'b0);
    check("ovf_run", s_state, 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
